// File: rtl/lscc_seg_pkg.sv
// Shared seven-segment font, segment type and per-digit counting step.
package lscc_seg_pkg;

    typedef logic [7:0] seg_t;

    typedef struct packed {
        logic [3:0] dig;
        logic       co;
    } dig_step_t;

    // {dp,g,f,e,d,c,b,a}, active-high; entry n is the glyph for nibble n
    localparam logic [15:0][7:0] HEX_FONT = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    // One digit of the ripple counter; co is carry (up) or borrow (down).
    function automatic dig_step_t digit_step(input logic [3:0] d, input logic up,
                                             input logic dec, input logic ci);
        dig_step_t  r;
        logic [3:0] top;
        top   = dec ? 4'd9 : 4'd15;
        r.dig = d;
        r.co  = 1'b0;
        if (ci) begin
            if (up) begin
                if (d >= top) begin
                    r.dig = 4'd0;
                    r.co  = 1'b1;
                end else begin
                    r.dig = d + 4'd1;
                end
            end else if (dec && d > 4'd9) begin
                r.dig = 4'd9;
            end else if (d == 4'd0) begin
                r.dig = top;
                r.co  = 1'b1;
            end else begin
                r.dig = d - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/svn_seg_scan_cntr_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int   DIV      = 1,
    parameter logic SIM_FAST = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'((DIV > 1) ? DIV - 1 : 0);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_o = SIM_FAST || (cnt_q == LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/svn_seg_scan_cntr.sv
// N-digit hex/BCD up/down counter scanned onto a multiplexed 7-segment display.
module svn_seg_scan_cntr
    import lscc_seg_pkg::*;
#(
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   NUM_DIGITS   = 3,
    parameter int   COUNT_HZ     = 1,
    parameter int   SCAN_HZ      = 1000,
    parameter logic SEG_POLARITY = 1'b0,
    parameter logic SEL_POLARITY = 1'b0,
    parameter logic SIM_FAST     = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    dec_mode_i,
    input  logic                    blank_lz_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic [7:0]              seg_display_o,
    output logic [NUM_DIGITS-1:0]   seg_sel_o
);
    localparam int CNT_RAW  = CLK_IN_MHZ * 1000000 / COUNT_HZ;
    localparam int CNT_DIV  = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int SCAN_RAW = CLK_IN_MHZ * 1000000 / (SCAN_HZ * NUM_DIGITS);
    localparam int SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
    localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam seg_t SEG_OFF = {8{~SEG_POLARITY}};
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{~SEL_POLARITY}};

    logic cnt_tick, scan_tick;

    tick_gen #(.DIV(CNT_DIV),  .SIM_FAST(SIM_FAST)) u_cnt_tick  (.clk_i(clk_i), .rst_i(rst_i), .tick_o(cnt_tick));
    tick_gen #(.DIV(SCAN_DIV), .SIM_FAST(SIM_FAST)) u_scan_tick (.clk_i(clk_i), .rst_i(rst_i), .tick_o(scan_tick));

    logic [4*NUM_DIGITS-1:0] count_q, count_d, step_cnt;
    logic                    wrap_q, wrap_d;
    logic [IW-1:0]           idx_q, idx_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    dig_step_t st   [NUM_DIGITS];
    logic      carry[NUM_DIGITS+1];
    logic      zsuf [NUM_DIGITS+1];

    // Ripple chain for the counter and the "this digit and all above are zero" chain for blanking
    assign carry[0]          = 1'b1;
    assign zsuf[NUM_DIGITS]  = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        assign st[g]              = digit_step(count_q[g*4 +: 4], up_i, dec_mode_i, carry[g]);
        assign step_cnt[g*4 +: 4] = st[g].dig;
        assign carry[g+1]         = st[g].co;
        assign zsuf[g]            = zsuf[g+1] & (count_q[g*4 +: 4] == 4'd0);
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && cnt_tick) begin
            count_d = step_cnt;
            wrap_d  = carry[NUM_DIGITS];
        end
    end

    logic [3:0] cur_nib;
    logic       cur_z;

    always_comb begin
        cur_nib = 4'd0;
        cur_z   = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (int'(idx_q) == j) begin
                cur_nib = count_q[j*4 +: 4];
                cur_z   = zsuf[j];
            end
        end
        idx_d = idx_q;
        if (scan_tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        seg_d = (blank_lz_i && idx_q != '0 && cur_z) ? 8'h00 : HEX_FONT[cur_nib];
        if (!SEG_POLARITY) seg_d = ~seg_d;
        sel_d = NUM_DIGITS'(1) << idx_q;
        if (!SEL_POLARITY) sel_d = ~sel_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            sel_q   <= SEL_IDLE;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign count_o       = count_q;
    assign wrap_o        = wrap_q;
    assign seg_display_o = seg_q;
    assign seg_sel_o     = sel_q;
endmodule

// File: tb/tb_svn_seg_scan_cntr.sv
// Directed vector bench for svn_seg_scan_cntr (3 digits, fast ticks, active-high polarities).
module tb_svn_seg_scan_cntr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, up = 1'b1, dec = 1'b0, blank = 1'b0, ld = 1'b0;
    logic [11:0] lv = '0;
    logic [11:0] count;
    logic        wrap;
    logic [7:0]  seg;
    logic [2:0]  sel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    svn_seg_scan_cntr #(
        .CLK_IN_MHZ(125), .NUM_DIGITS(3), .COUNT_HZ(1), .SCAN_HZ(1000),
        .SEG_POLARITY(1'b1), .SEL_POLARITY(1'b1), .SIM_FAST(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .dec_mode_i(dec),
        .blank_lz_i(blank), .load_i(ld), .load_val_i(lv),
        .count_o(count), .wrap_o(wrap), .seg_display_o(seg), .seg_sel_o(sel)
    );

    typedef struct {
        logic        ld;
        logic [11:0] lv;
        logic        en, up, dec;
        logic [11:0] ec;
        logic        ew;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Glyph expected on the segment bus for whichever digit is currently selected
    task automatic chk_digit(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
        case (sel)
            3'b001:  chk(name, seg, e0);
            3'b010:  chk(name, seg, e1);
            3'b100:  chk(name, seg, e2);
            default: chk({name, "_sel"}, sel, 3'b001);
        endcase
    endtask

    initial begin
        logic [2:0] prev_sel;

        //                ld    lv       en    up    dec   exp_cnt  exp_wrap
        tbl[0]  = '{1'b1, 12'hFFE, 1'b1, 1'b1, 1'b0, 12'hFFE, 1'b0};
        tbl[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'hFFF, 1'b0};
        tbl[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
        tbl[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h001, 1'b0};
        tbl[4]  = '{1'b1, 12'h100, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0};
        tbl[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h099, 1'b0};
        tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h098, 1'b0};
        tbl[7]  = '{1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0};
        tbl[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h999, 1'b1};
        tbl[9]  = '{1'b1, 12'h00C, 1'b1, 1'b1, 1'b1, 12'h00C, 1'b0};
        tbl[10] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0};
        tbl[11] = '{1'b1, 12'h00C, 1'b1, 1'b0, 1'b1, 12'h00C, 1'b0};
        tbl[12] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h009, 1'b0};
        tbl[13] = '{1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0};
        tbl[14] = '{1'b1, 12'h123, 1'b1, 1'b1, 1'b0, 12'h123, 1'b0};
        tbl[15] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h123, 1'b0};
        tbl[16] = '{1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
        tbl[17] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1};
        tbl[18] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0};

        // Reset state
        step();
        chk("rst_count", count, 12'h000);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_sel", sel, 3'b000);
        chk("rst_seg", seg, 8'h00);

        // Scan after release
        rst = 1'b0;
        step();
        chk("scan0_sel", sel, 3'b001);
        chk("scan0_seg", seg, 8'h3F);
        step();
        chk("scan1_sel", sel, 3'b010);
        chk("scan1_seg", seg, 8'h3F);
        step();
        chk("scan2_sel", sel, 3'b100);
        step();
        chk("scan3_sel", sel, 3'b001);
        step();
        chk("scan4_sel", sel, 3'b010);

        // Counter vectors: inputs for one edge, then outputs after it
        for (int i = 0; i < 19; i++) begin
            ld = tbl[i].ld; lv = tbl[i].lv; en = tbl[i].en; up = tbl[i].up; dec = tbl[i].dec;
            step();
            chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
            chk($sformatf("vec%0d_wrap", i), wrap, tbl[i].ew);
        end

        // Leading-zero blanking
        en = 1'b0; dec = 1'b0; blank = 1'b1;
        ld = 1'b1; lv = 12'h005;
        step();
        ld = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk_digit($sformatf("blank005_%0d", k), 8'h6D, 8'h00, 8'h00);
        end
        ld = 1'b1; lv = 12'h105;
        step();
        ld = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk_digit($sformatf("blank105_%0d", k), 8'h6D, 8'h3F, 8'h06);
        end

        // Enable low: count holds while the scan keeps moving
        prev_sel = sel;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold%0d_count", k), count, 12'h105);
            chk($sformatf("hold%0d_scan", k), (sel != prev_sel) ? 1'b1 : 1'b0, 1'b1);
            prev_sel = sel;
        end

        // Asynchronous reset mid-scan
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 12'h000);
        chk("arst_sel", sel, 3'b000);
        chk("arst_seg", seg, 8'h00);
        chk("arst_wrap", wrap, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("rerun_sel", sel, 3'b001);
        chk("rerun_seg", seg, 8'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
